trkbuf_ring: RTL

Parametrised single-clock dual-port track buffer for the floppy emulation path. Port A gives the host/SD loader random access to the buffered track. Port B is the drive-head side: a self-advancing circular byte pointer over a programmable track length, with an index pulse on wrap and a dirty flag for write-back. It maps to inferred block RAM and replaces the fixed 8K×8 track buffer instance.

---
 rtl/trkbuf_ring.sv | 115 +++++++++++
 1 files changed

// File: rtl/trkbuf_ring.sv
// Dual-port track buffer: random-access port A plus a self-advancing
// circular head on port B with index pulse and dirty tracking.
module trkbuf_ring #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 13,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    input  logic              a_dirty_clr,
    input  logic              b_load,
    input  logic [ADDR_W:0]   b_len,
    input  logic [ADDR_W-1:0] b_load_pos,
    input  logic              b_step,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_valid,
    output logic [ADDR_W-1:0] b_pos,
    output logic              b_wrap,
    output logic              dirty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_n;
    logic [ADDR_W-1:0] pos_n;
    logic              b_acc;
    logic              b_last;

    logic [DATA_W-1:0] a_d1;
    logic [DATA_W-1:0] b_d1;
    logic              a_v1;
    logic              b_v1;

    // A load in the same cycle as a step cancels the step entirely
    assign b_acc  = b_step & ~b_load;
    assign len_n  = (b_len == '0 || b_len > FULL) ? FULL : b_len;
    assign pos_n  = ({1'b0, b_load_pos} >= len_n) ? '0 : b_load_pos;
    assign b_last = ({1'b0, b_pos} == len_q - 1'b1);

    // Port A written last so it wins a same-address double write
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (b_acc && b_we) mem[b_pos] <= b_din;
            if (a_en && a_we) mem[a_addr] <= a_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_v1 <= 1'b0;
            a_d1 <= '0;
            b_v1 <= 1'b0;
            b_d1 <= '0;
        end else begin
            a_v1 <= a_en;
            if (a_en) a_d1 <= a_we ? a_din : mem[a_addr];
            b_v1 <= b_acc;
            if (b_acc) b_d1 <= b_we ? b_din : mem[b_pos];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q  <= FULL;
            b_pos  <= '0;
            b_wrap <= 1'b0;
            dirty  <= 1'b0;
        end else begin
            b_wrap <= b_acc & b_last;
            dirty  <= (b_acc & b_we) | (dirty & ~a_dirty_clr);
            if (b_load) begin
                len_q <= len_n;
                b_pos <= pos_n;
            end else if (b_acc) begin
                b_pos <= b_last ? '0 : b_pos + 1'b1;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_valid <= 1'b0;
                    a_dout  <= '0;
                    b_valid <= 1'b0;
                    b_dout  <= '0;
                end else begin
                    a_valid <= a_v1;
                    if (a_v1) a_dout <= a_d1;
                    b_valid <= b_v1;
                    if (b_v1) b_dout <= b_d1;
                end
            end
        end else begin : g_direct
            assign a_valid = a_v1;
            assign a_dout  = a_d1;
            assign b_valid = b_v1;
            assign b_dout  = b_d1;
        end
    endgenerate

endmodule
